uart_txbuf: RTL and testbench



---
 rtl/uart_txbuf_pkg.sv | 22 ++
 rtl/uart_txbuf_if.sv | 25 ++
 rtl/uart_txbuf_sync_fifo.sv | 51 +++++
 rtl/uart_txbuf.sv | 131 +++++++++++++
 tb/tb_uart_txbuf.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_txbuf_pkg.sv
// Shared constants and drain-FSM state type for the uart transmit buffer.
package uart_txbuf_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_USTAT  = 2'd3;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_OVF   = 2;

  localparam int unsigned CTL_CLROVF = 0;
  localparam int unsigned CTL_FLUSH  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POLL = 2'd1,
    SEND = 2'd2
  } drain_state_t;

endpackage

// File: rtl/uart_txbuf_if.sv
// CPU-side register bus and uart-side register port of the transmit buffer.
interface uart_txbuf_if;
  logic [1:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       u_cs;
  logic       u_rnw;
  logic       u_a0;
  logic [7:0] u_din;
  logic [7:0] u_dout;

  // master: the CPU plus uart surrounding the buffer
  modport master (
    output AD, DI, rw, cs, u_dout,
    input  DO, u_cs, u_rnw, u_a0, u_din
  );

  // slave: the buffer itself
  modport slave (
    input  AD, DI, rw, cs, u_dout,
    output DO, u_cs, u_rnw, u_a0, u_din
  );
endinterface

// File: rtl/uart_txbuf_sync_fifo.sv
// Byte FIFO with wrapping DEPTH_LOG2+1 bit pointers and unreset distributed-RAM storage.
module sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/uart_txbuf.sv
// CPU-side transmit buffer for the uart (decoded at $E6B0 in its place); drains bytes
// to the uart by polling its TX-ready flag and passes RX data/status reads through.
module uart_txbuf
  import uart_txbuf_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned TX_READY_BIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_txbuf_if.slave  bus
);

  logic                wr_q;
  logic                wr_edge;
  logic                push;
  logic                ctl_wr;
  logic                flush;
  logic                clr_ovf;
  logic                cpu_uart;
  logic                pop;
  logic                ovf;
  logic [7:0]          head;
  logic [DEPTH_LOG2:0] level;
  logic                full;
  logic                empty;
  drain_state_t        state;
  drain_state_t        state_n;

  assign wr_edge  = bus.cs & ~bus.rw & ~wr_q;
  assign push     = wr_edge & (bus.AD == REG_TXDATA);
  assign ctl_wr   = wr_edge & (bus.AD == REG_STATUS);
  assign flush    = ctl_wr & bus.DI[CTL_FLUSH];
  assign clr_ovf  = ctl_wr & bus.DI[CTL_CLROVF];
  assign cpu_uart = bus.cs & bus.AD[1];
  assign pop      = (state == SEND) & ~cpu_uart & ~flush;

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.DI),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      ovf   <= 1'b0;
      state <= IDLE;
    end else begin
      wr_q  <= bus.cs & ~bus.rw;
      state <= state_n;
      if (clr_ovf)
        ovf <= 1'b0;
      else if (push && full && !pop)
        ovf <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else if (!cpu_uart) begin
      unique case (state)
        IDLE:    if (!empty) state_n = POLL;
        POLL:    if (bus.u_dout[TX_READY_BIT]) state_n = SEND;
        SEND:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so a byte abandoned by reset never reaches the uart.
  always_comb begin
    bus.u_cs  = 1'b0;
    bus.u_rnw = 1'b1;
    bus.u_a0  = 1'b0;
    bus.u_din = '0;
    if (!rst) begin
      if (cpu_uart) begin
        if (bus.rw || bus.AD[0]) begin
          bus.u_cs  = 1'b1;
          bus.u_rnw = bus.rw;
          bus.u_a0  = bus.AD[0];
          bus.u_din = bus.DI;
        end
      end else begin
        unique case (state)
          POLL: begin
            bus.u_cs  = 1'b1;
            bus.u_rnw = 1'b1;
            bus.u_a0  = 1'b1;
          end
          SEND: begin
            bus.u_cs  = 1'b1;
            bus.u_rnw = 1'b0;
            bus.u_a0  = 1'b0;
            bus.u_din = head;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.DO = 8'hFF;
    if (bus.cs) begin
      unique case (bus.AD)
        REG_TXDATA: bus.DO = 8'(level);
        REG_STATUS: begin
          bus.DO           = '0;
          bus.DO[ST_EMPTY] = empty;
          bus.DO[ST_FULL]  = full;
          bus.DO[ST_OVF]   = ovf;
        end
        REG_RXDATA: bus.DO = bus.u_dout;
        REG_USTAT:  bus.DO = bus.u_dout;
        default:    bus.DO = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txbuf.sv
// Scoreboard bench: pushed bytes queue up as expected uart writes, a negedge monitor checks them.
module tb_uart_txbuf;

  localparam int unsigned DL    = 4;
  localparam int unsigned TXB   = 1;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_txbuf_if bus();

  uart_txbuf #(.DEPTH_LOG2(DL), .TX_READY_BIT(TXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_wcyc = 0;
  int sent = 0;
  int polls = 0;
  int ucs_seen = 0;

  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;

  logic       ready_fixed = 1'b1;
  logic       rnd_mode = 1'b0;
  logic       rnd_bit = 1'b1;
  logic [7:0] rxdat = 8'h3C;
  logic       ready_eff;
  logic [7:0] ustat;
  logic       poll_now;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rnd_bit <= ($urandom_range(0, 3) != 0);
    rxdat   <= 8'($urandom);
  end

  // uart model: a0=0 is RX data, a0=1 is status with the TX-ready flag
  always_comb begin
    ready_eff  = rnd_mode ? rnd_bit : ready_fixed;
    ustat      = 8'hA0;
    ustat[TXB] = ready_eff;
    bus.u_dout = bus.u_a0 ? ustat : rxdat;
  end

  assign poll_now = bus.u_cs && bus.u_rnw && bus.u_a0 && !(bus.cs && bus.AD[1]);

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.u_cs) ucs_seen++;
      if (poll_now) polls++;
      if (bus.u_cs && !bus.u_rnw && !bus.u_a0) begin
        sent++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_send: got %h expected no write", bus.u_din);
        end else begin
          check("send_data", bus.u_din, exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [7:0] model_do(logic [1:0] ad);
    case (ad)
      2'd0:    return 8'(exp_q.size());
      2'd1:    return {5'b0, m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
      2'd2:    return rxdat;
      default: return ustat;
    endcase
  endfunction

  task automatic cpu_write(logic [1:0] ad, logic [7:0] di, int unsigned hold);
    @(posedge clk);
    #1;
    bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = ad; bus.DI = di;
    last_wcyc = cyc;
    @(posedge clk);
    if (ad == 2'd0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(di);
      else m_ovf = 1'b1;
    end else if (ad == 2'd1) begin
      if (di[1]) exp_q.delete();
      if (di[0]) m_ovf = 1'b0;
    end
    repeat (hold - 1) @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.rw = 1'b1;
  endtask

  task automatic cpu_read(logic [1:0] ad, string name, output logic [7:0] val);
    @(posedge clk);
    #1;
    bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = ad;
    #2;
    val = bus.DO;
    check(name, bus.DO, model_do(ad));
    if (ad == 2'd2)
      check({name, "_port"}, {5'b0, bus.u_cs, bus.u_rnw, bus.u_a0}, 8'h06);
    @(posedge clk);
    #1;
    bus.cs = 1'b0;
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check(name, 8'(exp_q.size()), 8'h00);
  endtask

  initial begin
    logic [7:0] v;
    int s, p, u, fp;
    bus.cs = 1'b0; bus.rw = 1'b1; bus.AD = 2'd0; bus.DI = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    cpu_read(2'd1, "rst_status", v);
    check("rst_status_val", v, 8'h01);
    cpu_read(2'd0, "rst_level", v);
    check("rst_level_val", v, 8'h00);
    u = ucs_seen;
    repeat (20) @(posedge clk);
    check("idle_no_ucs", 8'(ucs_seen - u), 8'h00);

    // single byte, held write, poll latency
    ready_fixed = 1'b1;
    s = sent;
    fp = -1;
    fork
      cpu_write(2'd0, 8'h41, 3);
      begin
        for (int i = 0; i < 12 && fp < 0; i++) begin
          @(negedge clk);
          if (poll_now) fp = cyc;
        end
      end
    join
    check("first_poll_latency", 8'(fp - last_wcyc), 8'h02);
    wait_drain("drain_single", 50);
    check("one_send", 8'(sent - s), 8'h01);
    cpu_read(2'd0, "level_after_single", v);

    // fill to full with uart busy, overflow, then drain in order
    ready_fixed = 1'b0;
    p = polls;
    for (int i = 0; i < 17; i++) cpu_write(2'd0, 8'(i), 1);
    cpu_read(2'd0, "full_level", v);
    check("full_level_val", v, 8'h10);
    cpu_read(2'd1, "full_status", v);
    check("full_status_val", v, 8'h06);
    check("polls_while_busy", 8'((polls - p) >= 10), 8'h01);
    s = sent;
    ready_fixed = 1'b1;
    wait_drain("drain_full", 300);
    check("sends_after_full", 8'(sent - s), 8'h10);
    cpu_read(2'd1, "status_ovf_kept", v);
    check("status_ovf_kept_val", v, 8'h05);
    cpu_write(2'd1, 8'h01, 2);
    cpu_read(2'd1, "status_ovf_clr", v);
    check("status_ovf_clr_val", v, 8'h01);

    // random traffic with pass-through reads stealing the uart port
    rnd_mode = 1'b1;
    s = sent;
    for (int b = 0; b < 8; b++) begin
      cpu_write(2'd0, 8'($urandom), $urandom_range(1, 3));
      for (int r = 0; r < int'($urandom_range(0, 3)); r++) cpu_read(2'd2, "rx_pass", v);
      cpu_read(2'd3, "ustat_pass", v);
    end
    wait_drain("drain_random", 400);
    check("sends_random", 8'(sent - s), 8'h08);
    rnd_mode = 1'b0;

    // flush while the uart is busy
    ready_fixed = 1'b0;
    for (int i = 0; i < 5; i++) cpu_write(2'd0, 8'(8'hC0 + i), 1);
    s = sent;
    cpu_write(2'd1, 8'h02, 1);
    cpu_read(2'd1, "flush_status", v);
    check("flush_status_val", v, 8'h01);
    cpu_read(2'd0, "flush_level", v);
    check("flush_level_val", v, 8'h00);
    ready_fixed = 1'b1;
    repeat (20) @(posedge clk);
    check("no_send_after_flush", 8'(sent - s), 8'h00);

    // reset asserted during SEND
    cpu_write(2'd0, 8'h5A, 1);
    fp = -1;
    for (int i = 0; i < 12 && fp < 0; i++) begin
      @(negedge clk);
      if (poll_now) fp = cyc;
    end
    check("poll_before_rst", 8'(fp >= 0), 8'h01);
    @(posedge clk);
    #1 rst = 1'b1;
    #2 check("rst_cycle_ucs", {7'b0, bus.u_cs}, 8'h00);
    @(posedge clk);
    exp_q.delete();
    m_ovf = 1'b0;
    #1 rst = 1'b0;
    #1 check("post_rst_ucs", {7'b0, bus.u_cs}, 8'h00);
    cpu_read(2'd0, "post_rst_level", v);
    check("post_rst_level_val", v, 8'h00);
    cpu_read(2'd1, "post_rst_status", v);
    s = sent;
    cpu_write(2'd0, 8'h77, 1);
    wait_drain("drain_post_rst", 50);
    check("post_rst_send", 8'(sent - s), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
